// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transceiver: parity-mode
// constants, TX/RX state encodings and the bit-timer width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-cell timer: counts 0..CLKS_PER_BIT-1 while enabled and wraps; clr_i
// restarts it at zero. Strobes mark the mid-cell and last cycle of a cell.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic mid_o,
  output logic end_o
);

  localparam int W = timer_width(CLKS_PER_BIT);
  localparam logic [W-1:0] MID_CNT  = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] LAST_CNT = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mid_o = en_i && (cnt_q == MID_CNT);
  assign end_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_xcvr_param.sv
// Parametrised full-duplex UART transceiver with valid/ready handshakes and
// parity/framing/overrun reporting. Optional macro UART_LOOPBACK_EN adds loopback_i.
module uart_xcvr_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic                 uart_tx_o,
  input  logic                 uart_rx_i,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback_i,
`endif
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_overrun_o
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY_MODE != PAR_NONE);
  localparam logic       PAR_INV   = (PARITY_MODE == PAR_ODD);

  tx_state_e            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic                 tx_line_q, tx_line_d;
  logic                 uart_tx_q, uart_tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_mid_s, tx_end_s;

  rx_state_e            rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [1:0]           sync_q, sync_d;
  logic                 rx_src_s, rx_line_s, rx_en_s, rx_mid_s, rx_end_s, frame_done_s;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clr_i (tx_state_d != tx_state_q),
    .en_i  (tx_state_q != TX_IDLE),
    .mid_o (tx_mid_s),
    .end_o (tx_end_s)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clr_i (rx_state_d != rx_state_q),
    .en_i  (rx_en_s),
    .mid_o (rx_mid_s),
    .end_o (rx_end_s)
  );

  // The pad is driven one cycle behind the state, so START occupies edges N+1..N+CLKS_PER_BIT.
`ifdef UART_LOOPBACK_EN
  assign uart_tx_d = loopback_i ? 1'b1 : tx_line_d;
  assign rx_src_s  = loopback_i ? tx_line_q : uart_rx_i;
`else
  assign uart_tx_d = tx_line_d;
  assign rx_src_s  = uart_rx_i;
`endif

  // TX next-state, shifter and line level.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_bit_d   = tx_bit_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid_i && tx_ready_q) begin
          tx_shift_d = tx_data_i;
          tx_par_d   = (^tx_data_i) ^ PAR_INV;
          tx_bit_d   = 4'd0;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_end_s) tx_state_d = TX_DATA;
        else          tx_state_d = TX_START;
      end
      TX_DATA: begin
        if (tx_end_s) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_DATA) begin
            tx_bit_d   = 4'd0;
            tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (tx_end_s) tx_state_d = TX_STOP;
        else          tx_state_d = TX_PARITY;
      end
      TX_STOP: begin
        if (tx_end_s) begin
          if (tx_bit_q == LAST_STOP) tx_state_d = TX_IDLE;
          else                       tx_bit_d   = tx_bit_q + 4'd1;
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    case (tx_state_q)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shift_q[0];
      TX_PARITY: tx_line_d = tx_par_q;
      default:   tx_line_d = 1'b1;
    endcase

    tx_ready_d = (tx_state_d == TX_IDLE);
    tx_busy_d  = (tx_state_d != TX_IDLE);
  end

  assign sync_d    = {sync_q[0], rx_src_s};
  assign rx_line_s = sync_q[1];
  assign rx_en_s   = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH);

  // RX next-state and sampling; START samples mid-cell, later cells a full cell apart.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_shift_d   = rx_shift_q;
    rx_par_d     = rx_par_q;
    rx_bit_d     = rx_bit_q;
    frame_done_s = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_line_s) rx_state_d = RX_START;
        else            rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (rx_mid_s) begin
          rx_bit_d   = 4'd0;
          rx_state_d = rx_line_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_end_s) begin
          rx_shift_d = {rx_line_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_DATA) rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
          else                       rx_bit_d   = rx_bit_q + 4'd1;
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (rx_end_s) begin
          rx_par_d   = rx_line_s;
          rx_state_d = RX_STOP;
        end else begin
          rx_state_d = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (rx_end_s) begin
          frame_done_s = 1'b1;
          rx_state_d   = rx_line_s ? RX_IDLE : RX_WAIT_HIGH;
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_line_s) rx_state_d = RX_IDLE;
        else           rx_state_d = RX_WAIT_HIGH;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX holding register; a completed frame is dropped only when the held word is not being taken.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = 1'b0;
    if (frame_done_s) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = rx_shift_q;
        rx_perr_d  = PAR_EN && ((^rx_shift_q) ^ rx_par_q ^ PAR_INV);
        rx_ferr_d  = !rx_line_s;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // All state registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_bit_q   <= 4'd0;
      tx_line_q  <= 1'b1;
      uart_tx_q  <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      sync_q     <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_bit_q   <= 4'd0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
      uart_tx_q  <= uart_tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      sync_q     <= sync_d;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign tx_ready_o      = tx_ready_q;
  assign tx_busy_o       = tx_busy_q;
  assign uart_tx_o       = uart_tx_q;
  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_parity_err_o = rx_perr_q;
  assign rx_frame_err_o  = rx_ferr_q;
  assign rx_overrun_o    = rx_ovr_q;

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed self-checking bench for uart_xcvr_param: default, even-parity,
// odd-parity and 5-bit/7-clock/2-stop instances; loopback when UART_LOOPBACK_EN is set.
module tb_uart_xcvr_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // default instance: 8N1, 16 clocks per bit
  logic [7:0] txd_def = 8'h00, rxd_def;
  logic txv_def = 1'b0, txr_def, txb_def, txo_def;
  logic rxl_def = 1'b1, rxv_def, rxr_def = 1'b0, pe_def, fe_def, ov_def;
  logic lb_def = 1'b0;
  // even-parity transmitter
  logic [7:0] txd_ev = 8'h00, rxd_ev;
  logic txv_ev = 1'b0, txr_ev, txb_ev, txo_ev, rxv_ev, pe_ev, fe_ev, ov_ev;
  // odd-parity receiver
  logic [7:0] rxd_odd;
  logic txr_odd, txb_odd, txo_odd;
  logic rxl_odd = 1'b1, rxv_odd, rxr_odd = 1'b0, pe_odd, fe_odd, ov_odd;
  // 5 data bits, 7 clocks per bit, 2 stop bits, wired to itself
  logic [4:0] txd_sm = 5'h00, rxd_sm;
  logic txv_sm = 1'b0, txr_sm, txb_sm, txo_sm, rxv_sm, pe_sm, fe_sm, ov_sm;

  uart_xcvr_param u_def (
    .sys_clk(clk), .sys_rst(rst), .tx_data_i(txd_def), .tx_valid_i(txv_def),
    .tx_ready_o(txr_def), .tx_busy_o(txb_def), .uart_tx_o(txo_def), .uart_rx_i(rxl_def),
`ifdef UART_LOOPBACK_EN
    .loopback_i(lb_def),
`endif
    .rx_data_o(rxd_def), .rx_valid_o(rxv_def), .rx_ready_i(rxr_def),
    .rx_parity_err_o(pe_def), .rx_frame_err_o(fe_def), .rx_overrun_o(ov_def));

  uart_xcvr_param #(.PARITY_MODE(1)) u_even (
    .sys_clk(clk), .sys_rst(rst), .tx_data_i(txd_ev), .tx_valid_i(txv_ev),
    .tx_ready_o(txr_ev), .tx_busy_o(txb_ev), .uart_tx_o(txo_ev), .uart_rx_i(1'b1),
`ifdef UART_LOOPBACK_EN
    .loopback_i(1'b0),
`endif
    .rx_data_o(rxd_ev), .rx_valid_o(rxv_ev), .rx_ready_i(1'b0),
    .rx_parity_err_o(pe_ev), .rx_frame_err_o(fe_ev), .rx_overrun_o(ov_ev));

  uart_xcvr_param #(.PARITY_MODE(2)) u_odd (
    .sys_clk(clk), .sys_rst(rst), .tx_data_i(8'h00), .tx_valid_i(1'b0),
    .tx_ready_o(txr_odd), .tx_busy_o(txb_odd), .uart_tx_o(txo_odd), .uart_rx_i(rxl_odd),
`ifdef UART_LOOPBACK_EN
    .loopback_i(1'b0),
`endif
    .rx_data_o(rxd_odd), .rx_valid_o(rxv_odd), .rx_ready_i(rxr_odd),
    .rx_parity_err_o(pe_odd), .rx_frame_err_o(fe_odd), .rx_overrun_o(ov_odd));

  uart_xcvr_param #(.DATA_BITS(5), .CLKS_PER_BIT(7), .STOP_BITS(2)) u_small (
    .sys_clk(clk), .sys_rst(rst), .tx_data_i(txd_sm), .tx_valid_i(txv_sm),
    .tx_ready_o(txr_sm), .tx_busy_o(txb_sm), .uart_tx_o(txo_sm), .uart_rx_i(txo_sm),
`ifdef UART_LOOPBACK_EN
    .loopback_i(1'b0),
`endif
    .rx_data_o(rxd_sm), .rx_valid_o(rxv_sm), .rx_ready_i(1'b0),
    .rx_parity_err_o(pe_sm), .rx_frame_err_o(fe_sm), .rx_overrun_o(ov_sm));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // one 16-clock bit cell on the default (sel 0) or odd-parity (sel 1) RX line
  task automatic rx_bit(input int sel, input logic b);
    if (sel == 0) rxl_def = b;
    else          rxl_odd = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_rx(input int sel, input logic [7:0] d, input logic has_par,
                         input logic par, input logic stop);
    rx_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) rx_bit(sel, d[i]);
    if (has_par) rx_bit(sel, par);
    rx_bit(sel, stop);
  endtask

  task automatic consume_def();
    rxr_def = 1'b1; @(negedge clk); rxr_def = 1'b0; @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (txo_def !== 1'b1) begin n_fail++; $display("FAIL reset_tx_line: got %b want 1", txo_def); end
    n_tests++; if (txr_def !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", txr_def); end
    n_tests++; if (txb_def !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b want 0", txb_def); end
    n_tests++; if ({rxv_def, pe_def, fe_def, ov_def} !== 4'b0000) begin n_fail++; $display("FAIL reset_rx_flags: got %b want 0000", {rxv_def, pe_def, fe_def, ov_def}); end
    n_tests++; if (rxd_def !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rxd_def); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_parity();
    logic [10:0] cells;
    cells = {1'b1, 1'b0, 8'hA5, 1'b0};
    txd_ev = 8'hA5; txv_ev = 1'b1;
    @(negedge clk);
    txv_ev = 1'b0;
    n_tests++; if ({txr_ev, txb_ev} !== 2'b01) begin n_fail++; $display("FAIL tx_handshake: ready/busy got %b want 01", {txr_ev, txb_ev}); end
    txd_ev = 8'h00; txv_ev = 1'b1;
    repeat (8) @(negedge clk);
    for (int j = 0; j < 11; j++) begin
      n_tests++; if (txo_ev !== cells[j]) begin n_fail++; $display("FAIL tx_a5_cell%0d: got %b want %b", j, txo_ev, cells[j]); end
      if (j == 9) txv_ev = 1'b0;
      if (j < 10) repeat (16) @(negedge clk);
    end
    repeat (7) @(negedge clk);
    n_tests++; if (txr_ev !== 1'b0) begin n_fail++; $display("FAIL tx_ready_175: got %b want 0", txr_ev); end
    @(negedge clk);
    n_tests++; if ({txr_ev, txb_ev, txo_ev} !== 3'b101) begin n_fail++; $display("FAIL tx_ready_176: ready/busy/line got %b want 101", {txr_ev, txb_ev, txo_ev}); end
  endtask

  task automatic test_rx_overrun();
    int pulses = 0;
    send_rx(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    n_tests++; if (rxv_def !== 1'b1) begin n_fail++; $display("FAIL rx_3c_valid: got %b want 1", rxv_def); end
    n_tests++; if (rxd_def !== 8'h3C) begin n_fail++; $display("FAIL rx_3c_data: got %h want 3c", rxd_def); end
    n_tests++; if ({pe_def, fe_def} !== 2'b00) begin n_fail++; $display("FAIL rx_3c_errs: got %b want 00", {pe_def, fe_def}); end
    fork
      send_rx(0, 8'h55, 1'b0, 1'b0, 1'b1);
      begin
        repeat (175) begin @(negedge clk); if (ov_def === 1'b1) pulses++; end
      end
    join
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL rx_overrun_pulses: got %0d want 1", pulses); end
    n_tests++; if ({rxv_def, rxd_def} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL rx_overrun_hold: got %b/%h want 1/3c", rxv_def, rxd_def); end
    consume_def();
    n_tests++; if (rxv_def !== 1'b0) begin n_fail++; $display("FAIL rx_consume: valid got %b want 0", rxv_def); end
  endtask

  task automatic test_glitch();
    rxl_def = 1'b0;
    repeat (5) @(negedge clk);
    rxl_def = 1'b1;
    repeat (40) @(negedge clk);
    n_tests++; if (rxv_def !== 1'b0) begin n_fail++; $display("FAIL glitch_no_valid: got %b want 0", rxv_def); end
    send_rx(0, 8'h81, 1'b0, 1'b0, 1'b1);
    n_tests++; if ({rxv_def, rxd_def} !== {1'b1, 8'h81}) begin n_fail++; $display("FAIL glitch_then_81: got %b/%h want 1/81", rxv_def, rxd_def); end
    consume_def();
  endtask

  task automatic test_errors();
    // 0x0F has four ones: odd parity expects a 1 on the line
    send_rx(1, 8'h0F, 1'b1, 1'b0, 1'b1);
    n_tests++; if ({rxv_odd, pe_odd, rxd_odd} !== {2'b11, 8'h0F}) begin n_fail++; $display("FAIL odd_par_bad: valid/perr/data got %b%b/%h want 11/0f", rxv_odd, pe_odd, rxd_odd); end
    rxr_odd = 1'b1; @(negedge clk); rxr_odd = 1'b0;
    send_rx(1, 8'h0F, 1'b1, 1'b1, 1'b1);
    n_tests++; if ({rxv_odd, pe_odd, fe_odd} !== 3'b100) begin n_fail++; $display("FAIL odd_par_good: valid/perr/ferr got %b want 100", {rxv_odd, pe_odd, fe_odd}); end
    send_rx(0, 8'h7E, 1'b0, 1'b0, 1'b0);
    n_tests++; if ({rxv_def, fe_def, pe_def, rxd_def} !== {3'b110, 8'h7E}) begin n_fail++; $display("FAIL frame_err: valid/ferr/perr/data got %b/%h want 110/7e", {rxv_def, fe_def, pe_def}, rxd_def); end
    consume_def();
    repeat (200) @(negedge clk);
    n_tests++; if (rxv_def !== 1'b0) begin n_fail++; $display("FAIL break_wait_high: valid got %b want 0", rxv_def); end
    rxl_def = 1'b1;
    repeat (20) @(negedge clk);
    send_rx(0, 8'h42, 1'b0, 1'b0, 1'b1);
    n_tests++; if ({rxv_def, fe_def, rxd_def} !== {2'b10, 8'h42}) begin n_fail++; $display("FAIL after_break_42: valid/ferr/data got %b/%h want 10/42", {rxv_def, fe_def}, rxd_def); end
  endtask

  task automatic test_reset_midframe();
    txd_ev = 8'hFF; txv_ev = 1'b1;
    @(negedge clk);
    txv_ev = 1'b0;
    rxl_def = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1; rxl_def = 1'b1;
    @(negedge clk);
    n_tests++; if ({txo_ev, txr_ev, txb_ev} !== 3'b110) begin n_fail++; $display("FAIL midframe_rst_tx: line/ready/busy got %b want 110", {txo_ev, txr_ev, txb_ev}); end
    n_tests++; if ({rxv_def, rxd_def} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL midframe_rst_rx: got %b/%h want 0/00", rxv_def, rxd_def); end
    rst = 1'b0;
    repeat (200) @(negedge clk);
    n_tests++; if (rxv_def !== 1'b0) begin n_fail++; $display("FAIL midframe_rx_discard: valid got %b want 0", rxv_def); end
  endtask

  task automatic test_small_cfg();
    logic [7:0] cells;
    cells = {2'b11, 5'h1B, 1'b0};
    txd_sm = 5'h1B; txv_sm = 1'b1;
    @(negedge clk);
    txv_sm = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      n_tests++; if (txo_sm !== cells[j]) begin n_fail++; $display("FAIL small_cell%0d: got %b want %b", j, txo_sm, cells[j]); end
      if (j < 7) repeat (7) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    n_tests++; if (txr_sm !== 1'b0) begin n_fail++; $display("FAIL small_ready_55: got %b want 0", txr_sm); end
    @(negedge clk);
    n_tests++; if (txr_sm !== 1'b1) begin n_fail++; $display("FAIL small_ready_56: got %b want 1", txr_sm); end
    n_tests++; if ({rxv_sm, fe_sm, rxd_sm} !== {2'b10, 5'h1B}) begin n_fail++; $display("FAIL small_rx: valid/ferr/data got %b/%h want 10/1b", {rxv_sm, fe_sm}, rxd_sm); end
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback();
    int high_bad = 0;
    lb_def = 1'b1;
    repeat (2) @(negedge clk);
    txd_def = 8'hC3; txv_def = 1'b1;
    @(negedge clk);
    txv_def = 1'b0;
    repeat (200) begin @(negedge clk); if (txo_def !== 1'b1) high_bad++; end
    n_tests++; if (high_bad != 0) begin n_fail++; $display("FAIL loopback_pad_high: %0d low cycles want 0", high_bad); end
    n_tests++; if ({rxv_def, rxd_def} !== {1'b1, 8'hC3}) begin n_fail++; $display("FAIL loopback_rx: got %b/%h want 1/c3", rxv_def, rxd_def); end
    lb_def = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_tx_parity();
    test_rx_overrun();
    test_glitch();
    test_errors();
    test_reset_midframe();
    test_small_cfg();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
